// File: rtl/snf_txdat_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snf_txdat_arb_pkg
// Brief    : Shared constants for the SNF TXDAT arbiter: flit width, default
//            sizing and FSM state encodings.
// Revision : 1.0
// ============================================================================
package snf_txdat_arb_pkg;

  localparam int CHIE_DAT_FLIT_WIDTH = 64;

  localparam int SNF_NUM_REQ_DFLT   = 4;
  localparam int SNF_MAX_BEATS_DFLT = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage
`default_nettype wire

// File: rtl/snf_txdat_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : snf_txdat_arb_if
// Brief    : Requester / TXDAT handshake bundle around the TXDAT arbiter.
// Revision : 1.0
// ============================================================================
interface snf_txdat_arb_if
  import snf_txdat_arb_pkg::*;
#(
  parameter int NUM_REQ = SNF_NUM_REQ_DFLT
);
  logic [NUM_REQ-1:0]                     req_valid_sx;
  logic [NUM_REQ-1:0]                     req_last_sx;
  logic [NUM_REQ*CHIE_DAT_FLIT_WIDTH-1:0] req_flit_sx;
  logic                                   txdat_dbf_rdy_s1;
  logic                                   txdat_dbf_won_sx;
  logic                                   dbf_txdat_valid_sx;
  logic [CHIE_DAT_FLIT_WIDTH-1:0]         txdat_flit;
  logic [NUM_REQ-1:0]                     arb_req_gnt_sx;
  logic                                   arb_busy;
  logic                                   arb_err_sx;

  modport slave (
    input  req_valid_sx, req_last_sx, req_flit_sx,
    input  txdat_dbf_rdy_s1, txdat_dbf_won_sx,
    output dbf_txdat_valid_sx, txdat_flit, arb_req_gnt_sx, arb_busy, arb_err_sx
  );

  modport master (
    output req_valid_sx, req_last_sx, req_flit_sx,
    output txdat_dbf_rdy_s1, txdat_dbf_won_sx,
    input  dbf_txdat_valid_sx, txdat_flit, arb_req_gnt_sx, arb_busy, arb_err_sx
  );
endinterface
`default_nettype wire

// File: rtl/snf_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : snf_rr_arb
// Brief    : Combinational round-robin picker: first valid, non-excluded
//            requester at or after the start index, wrapping.
// Revision : 1.0
// ============================================================================
module snf_rr_arb
  import snf_txdat_arb_pkg::*;
#(
  parameter int NUM_REQ = SNF_NUM_REQ_DFLT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] valid,
  input  wire logic [NUM_REQ-1:0] excl,
  input  wire logic [IDX_W-1:0]   start,
  output logic                    found,
  output logic [IDX_W-1:0]        idx
);

  logic [NUM_REQ-1:0]   w_cand;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;

  // Rotate so that bit 0 is the start index; the lowest set bit wins.
  assign w_cand = valid & ~excl;
  assign w_dbl  = {w_cand, w_cand};
  assign w_rot  = w_dbl[start +: NUM_REQ];

  always_comb begin
    found = 1'b0;
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found = 1'b1;
        w_off = IDX_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, start} + {1'b0, w_off};
  assign idx   = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                : IDX_W'(w_sum);

endmodule
`default_nettype wire

// File: rtl/snf_txdat_arb.sv
`default_nettype none
// ============================================================================
// Module   : snf_txdat_arb
// Brief    : Burst-locking round-robin arbiter feeding DAT flits to TXDAT.
// Revision : 1.0
// ============================================================================
module snf_txdat_arb
  import snf_txdat_arb_pkg::*;
#(
  parameter int NUM_REQ   = SNF_NUM_REQ_DFLT,
  parameter int MAX_BEATS = SNF_MAX_BEATS_DFLT
) (
  input  wire logic      clk,
  input  wire logic      rst,
  snf_txdat_arb_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic               w_send;
  logic               w_won;
  logic               w_sel_last;
  logic [NUM_REQ-1:0] w_sel_oh;
  logic [IDX_W-1:0]   w_sel_inc;
  logic [CNT_W-1:0]   w_beat_next;
  logic               w_force;
  logic               w_release;
  logic [IDX_W-1:0]   w_arb_start;
  logic [NUM_REQ-1:0] w_arb_excl;
  logic               w_arb_found;
  logic [IDX_W-1:0]   w_arb_idx;

  assign w_send      = (state == ST_SEND);
  assign w_won       = w_send & bus.txdat_dbf_won_sx;
  assign w_sel_last  = bus.req_last_sx[sel_q];
  assign w_sel_oh    = NUM_REQ'(1) << sel_q;
  assign w_sel_inc   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
  assign w_beat_next = beat_cnt_q + CNT_W'(1);
  assign w_force     = w_won & ~w_sel_last & (w_beat_next == CNT_W'(MAX_BEATS));
  assign w_release   = w_won & (w_sel_last | w_force);

  // In SEND the picker pre-computes the handover target so a release can
  // switch requesters without an IDLE bubble.
  assign w_arb_start = w_send ? w_sel_inc : rr_ptr_q;
  assign w_arb_excl  = w_send ? w_sel_oh  : '0;

  snf_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .valid (bus.req_valid_sx),
    .excl  (w_arb_excl),
    .start (w_arb_start),
    .found (w_arb_found),
    .idx   (w_arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (w_arb_found) begin
            sel_q      <= w_arb_idx;
            beat_cnt_q <= '0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_release) begin
            rr_ptr_q   <= w_sel_inc;
            beat_cnt_q <= '0;
            if (w_arb_found) begin
              sel_q <= w_arb_idx;
            end else begin
              state <= ST_IDLE;
            end
          end else if (w_won) begin
            beat_cnt_q <= w_beat_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dbf_txdat_valid_sx = w_send & bus.req_valid_sx[sel_q];
  assign bus.txdat_flit         = w_send ? bus.req_flit_sx[sel_q*CHIE_DAT_FLIT_WIDTH +: CHIE_DAT_FLIT_WIDTH]
                                         : '0;
  assign bus.arb_req_gnt_sx     = w_won ? w_sel_oh : '0;
  assign bus.arb_busy           = w_send;
  assign bus.arb_err_sx         = w_force;

endmodule
`default_nettype wire

// File: tb/tb_snf_txdat_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_snf_txdat_arb
// Brief    : Self-checking bench: per-cycle vector table plus a grant-order
//            scoreboard driven by a reactive TXDAT model.
// Revision : 1.0
// ============================================================================
module tb_snf_txdat_arb;
  import snf_txdat_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = CHIE_DAT_FLIT_WIDTH;

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
    logic            rdy;
    logic            won;
    logic            e_valid;
    int              e_sel;
    logic [NREQ-1:0] e_gnt;
    logic            e_busy;
    logic            e_err;
    int              e_rr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_mis;
  vec_t vecs[$];
  int   sb[$];

  snf_txdat_arb_if #(.NUM_REQ(NREQ)) bus ();

  snf_txdat_arb #(
    .NUM_REQ   (NREQ),
    .MAX_BEATS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] pat(input int i);
    return W'({16{4'(i + 1)}}) ^ W'(64'h0F0F_00FF_F0F0_FF00);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic rd, input logic wn, input logic ev, input int es,
                     input logic [3:0] eg, input logic eb, input logic ee, input int er);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.rdy = rd; t.won = wn;
    t.e_valid = ev; t.e_sel = es; t.e_gnt = eg; t.e_busy = eb; t.e_err = ee; t.e_rr = er;
    vecs.push_back(t);
  endtask

  initial begin
    logic            launch;
    logic [NREQ-1:0] gnt;
    int              exp_idx;
    int              gap;
    int              oh_viol;
    bit              first;

    n_vec = 0;
    n_mis = 0;

    //   rst valid    last     rdy won  ev  sel  gnt      busy err rr
    // Requester 2 alone, two-beat burst, beats four cycles apart.
    add(0, 4'b0100, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  0);
    add(0, 4'b0100, 4'b0000, 1, 0,   1,  2, 4'b0000, 1, 0, -1);
    add(0, 4'b0100, 4'b0000, 1, 1,   1,  2, 4'b0100, 1, 0, -1);
    add(0, 4'b0000, 4'b0000, 1, 0,   0,  2, 4'b0000, 1, 0, -1);
    add(0, 4'b0000, 4'b0000, 1, 0,   0,  2, 4'b0000, 1, 0, -1);
    add(0, 4'b0100, 4'b0100, 1, 0,   1,  2, 4'b0000, 1, 0, -1);
    add(0, 4'b0100, 4'b0100, 1, 1,   1,  2, 4'b0100, 1, 0, -1);
    add(0, 4'b0000, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  3);
    // Requester 1 with TXDAT not ready for five cycles.
    add(0, 4'b0010, 4'b0010, 0, 0,   0, -1, 4'b0000, 0, 0,  3);
    for (int k = 0; k < 5; k++)
      add(0, 4'b0010, 4'b0010, 0, 0, 1,  1, 4'b0000, 1, 0, -1);
    add(0, 4'b0010, 4'b0010, 1, 0,   1,  1, 4'b0000, 1, 0, -1);
    add(0, 4'b0010, 4'b0010, 1, 1,   1,  1, 4'b0010, 1, 0, -1);
    add(0, 4'b0000, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  2);
    // Spurious won while IDLE.
    add(0, 4'b0000, 4'b0000, 1, 1,   0, -1, 4'b0000, 0, 0,  2);
    add(0, 4'b0000, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  2);
    // Requester 0 never asserts last: forced release on the second beat.
    add(0, 4'b0001, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  2);
    add(0, 4'b0001, 4'b0000, 1, 0,   1,  0, 4'b0000, 1, 0, -1);
    add(0, 4'b0001, 4'b0000, 1, 1,   1,  0, 4'b0001, 1, 0, -1);
    add(0, 4'b0001, 4'b0000, 1, 0,   1,  0, 4'b0000, 1, 0, -1);
    add(0, 4'b0001, 4'b0000, 1, 1,   1,  0, 4'b0001, 1, 1, -1);
    add(0, 4'b0001, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  1);
    add(0, 4'b0001, 4'b0000, 1, 0,   1,  0, 4'b0000, 1, 0, -1);
    add(0, 4'b0001, 4'b0000, 1, 1,   1,  0, 4'b0001, 1, 0, -1);
    // Reset mid-burst after beat 1; pointer and beat count restart.
    add(0, 4'b0001, 4'b0000, 1, 0,   1,  0, 4'b0000, 1, 0, -1);
    add(1, 4'b0001, 4'b0000, 1, 0,   1,  0, 4'b0000, 1, 0, -1);
    add(0, 4'b0011, 4'b0000, 1, 0,   0, -1, 4'b0000, 0, 0,  0);
    add(0, 4'b0011, 4'b0000, 1, 0,   1,  0, 4'b0000, 1, 0, -1);
    add(0, 4'b0011, 4'b0000, 1, 1,   1,  0, 4'b0001, 1, 0, -1);

    bus.req_valid_sx     = '0;
    bus.req_last_sx      = '0;
    bus.txdat_dbf_rdy_s1 = 1'b1;
    bus.txdat_dbf_won_sx = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.req_flit_sx[i*W +: W] = pat(i);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst                  = vecs[i].rst;
      bus.req_valid_sx     = vecs[i].valid;
      bus.req_last_sx      = vecs[i].last;
      bus.txdat_dbf_rdy_s1 = vecs[i].rdy;
      bus.txdat_dbf_won_sx = vecs[i].won;
      @(negedge clk);
      chk($sformatf("v%0d valid", i), 64'(bus.dbf_txdat_valid_sx), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d flit", i), 64'(bus.txdat_flit),
          (vecs[i].e_sel < 0) ? 64'd0 : 64'(pat(vecs[i].e_sel)));
      chk($sformatf("v%0d gnt", i), 64'(bus.arb_req_gnt_sx), 64'(vecs[i].e_gnt));
      chk($sformatf("v%0d busy", i), 64'(bus.arb_busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d err", i), 64'(bus.arb_err_sx), 64'(vecs[i].e_err));
      if (vecs[i].e_rr >= 0)
        chk($sformatf("v%0d rr_ptr", i), 64'(dut.rr_ptr_q), 64'(vecs[i].e_rr));
      @(posedge clk);
      #1;
    end

    // All four requesters busy with single-beat bursts: fair, bubble-free order.
    rst              = 1'b1;
    bus.req_valid_sx = '0;
    bus.txdat_dbf_won_sx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst                  = 1'b0;
    bus.req_valid_sx     = '1;
    bus.req_last_sx      = '1;
    bus.txdat_dbf_rdy_s1 = 1'b1;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
    gap     = 0;
    oh_viol = 0;
    first   = 1'b1;
    for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      gnt    = bus.arb_req_gnt_sx;
      launch = bus.dbf_txdat_valid_sx & bus.txdat_dbf_rdy_s1 & ~bus.txdat_dbf_won_sx;
      if (!$onehot0(gnt)) oh_viol++;
      gap++;
      if (gnt != '0) begin
        exp_idx = sb.pop_front();
        chk($sformatf("sb grant to %0d", exp_idx), 64'(gnt), 64'(NREQ'(1) << exp_idx));
        chk($sformatf("sb flit of %0d", exp_idx), 64'(bus.txdat_flit), 64'(pat(exp_idx)));
        if (!first) chk("sb grant spacing", 64'(gap), 64'd2);
        first = 1'b0;
        gap   = 0;
      end
      @(posedge clk);
      #1;
      bus.txdat_dbf_won_sx = launch;
    end
    chk("sb grants outstanding", 64'(sb.size()), 64'd0);
    chk("sb onehot violations", 64'(oh_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
